// File: rtl/baud_pkg.sv
// Shared types and constants for the baud/bit-timing generator.
// Holds the phase state enum, width constants and the default minimum period.
package baud_pkg;

    localparam int PER_W          = 16;
    localparam int CNT_W          = 4;
    localparam int IDX_W          = 5;
    localparam int MIN_PERIOD_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_e;

    function automatic logic [PER_W-1:0] eff_period(
        input logic [PER_W-1:0] rate,
        input logic [PER_W-1:0] min_p
    );
        return (rate < min_p) ? min_p : rate;
    endfunction

endpackage

// File: rtl/baud_period_counter.sv
// Interval counter: counts 0..limit and flags terminal count.
// Load restarts the interval with a new limit; clear only zeroes the count.
module baud_period_counter
    import baud_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_load,
    input  logic             i_clr,
    input  logic [PER_W-1:0] i_limit,
    output logic             o_tc
);

    logic [PER_W-1:0] r_cnt;
    logic [PER_W-1:0] r_lim;

    assign o_tc = (r_cnt == r_lim);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_lim <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
            r_lim <= i_limit;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tc ? '0 : r_cnt + PER_W'(1);
        end
    end

endmodule

// File: rtl/baud_generate.sv
// Bit-timing generator: up-phase strobes every P+1 clocks, then down-phase
// strobes every P clocks; config is captured only at the start of each bit.
module baud_generate
    import baud_pkg::*;
#(
    parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p_Enable_i,
    input  logic             p_Restart_i,
    input  logic [PER_W-1:0] BaudRateGen_i,
    input  logic [7:0]       BitCompensateMethod_i,
    output logic             p_AcqSig_o,
    output logic             p_BitEnd_o,
    output logic [IDX_W-1:0] AcqIdx_o,
    output logic             p_Busy_o,
    output logic             p_CfgErr_o
);

    localparam logic [PER_W-1:0] MIN_P = PER_W'(MIN_PERIOD);

    state_e           r_state, w_state_n;
    logic [CNT_W-1:0] r_up, w_up_n, r_dn, w_dn_n;
    logic [PER_W-1:0] r_period, w_period_n;
    logic [CNT_W-1:0] r_phcnt, w_phcnt_n;
    logic [IDX_W-1:0] r_idx, w_idx_n;
    logic             r_acq, w_acq_n;
    logic             r_bitend, w_bitend_n;
    logic [IDX_W-1:0] r_acqidx, w_acqidx_n;
    logic             r_busy;
    logic             r_cfgerr, w_cfgerr_n;

    logic             w_ld, w_clr, w_tc, w_start, w_cnt_en;
    logic [PER_W-1:0] w_lim;
    logic [PER_W-1:0] w_p_in;
    logic [CNT_W-1:0] w_up_in, w_dn_in, w_ph_inc;
    logic [IDX_W-1:0] w_n_in, w_n_cur, w_idx_inc;

    assign w_up_in   = BitCompensateMethod_i[7:4];
    assign w_dn_in   = BitCompensateMethod_i[3:0];
    assign w_p_in    = eff_period(BaudRateGen_i, MIN_P);
    assign w_n_in    = {1'b0, w_up_in} + {1'b0, w_dn_in};
    assign w_n_cur   = {1'b0, r_up} + {1'b0, r_dn};
    assign w_idx_inc = r_idx + IDX_W'(1);
    assign w_ph_inc  = r_phcnt + CNT_W'(1);
    assign w_cnt_en  = (r_state != ST_IDLE);

    baud_period_counter u_period (
        .clk     (clk),
        .rst_n   (rst),
        .i_en    (w_cnt_en),
        .i_load  (w_ld),
        .i_clr   (w_clr),
        .i_limit (w_lim),
        .o_tc    (w_tc)
    );

    always_comb begin
        w_state_n  = r_state;
        w_up_n     = r_up;
        w_dn_n     = r_dn;
        w_period_n = r_period;
        w_phcnt_n  = r_phcnt;
        w_idx_n    = r_idx;
        w_acq_n    = 1'b0;
        w_bitend_n = 1'b0;
        w_acqidx_n = '0;
        w_cfgerr_n = r_cfgerr;
        w_ld       = 1'b0;
        w_clr      = 1'b0;
        w_lim      = r_period;
        w_start    = 1'b0;

        if (!p_Enable_i) begin
            w_state_n = ST_IDLE;
            w_clr     = 1'b1;
            w_phcnt_n = '0;
            w_idx_n   = '0;
        end else if (r_state == ST_IDLE || p_Restart_i) begin
            w_start = 1'b1;
        end else if (w_tc) begin
            w_acq_n    = 1'b1;
            w_acqidx_n = w_idx_inc;
            w_idx_n    = w_idx_inc;
            if (w_idx_inc == w_n_cur) begin
                w_bitend_n = 1'b1;
                w_start    = 1'b1;
            end else if (r_state == ST_UP && w_ph_inc == r_up) begin
                w_state_n = ST_DOWN;
                w_phcnt_n = '0;
                w_ld      = 1'b1;
                w_lim     = r_period - PER_W'(1);
            end else begin
                w_phcnt_n = w_ph_inc;
            end
        end

        // A new bit recaptures config; an empty bit parks in IDLE.
        if (w_start) begin
            w_up_n     = w_up_in;
            w_dn_n     = w_dn_in;
            w_period_n = w_p_in;
            w_phcnt_n  = '0;
            w_idx_n    = '0;
            if (w_n_in == '0) begin
                w_state_n  = ST_IDLE;
                w_cfgerr_n = 1'b1;
                w_clr      = 1'b1;
            end else begin
                w_ld      = 1'b1;
                w_state_n = (w_up_in != '0) ? ST_UP : ST_DOWN;
                w_lim     = (w_up_in != '0) ? w_p_in : w_p_in - PER_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_up     <= '0;
            r_dn     <= '0;
            r_period <= '0;
            r_phcnt  <= '0;
            r_idx    <= '0;
            r_acq    <= 1'b0;
            r_bitend <= 1'b0;
            r_acqidx <= '0;
            r_busy   <= 1'b0;
            r_cfgerr <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_up     <= w_up_n;
            r_dn     <= w_dn_n;
            r_period <= w_period_n;
            r_phcnt  <= w_phcnt_n;
            r_idx    <= w_idx_n;
            r_acq    <= w_acq_n;
            r_bitend <= w_bitend_n;
            r_acqidx <= w_acqidx_n;
            r_busy   <= (w_state_n != ST_IDLE);
            r_cfgerr <= w_cfgerr_n;
        end
    end

    assign p_AcqSig_o = r_acq;
    assign p_BitEnd_o = r_bitend;
    assign AcqIdx_o   = r_acqidx;
    assign p_Busy_o   = r_busy;
    assign p_CfgErr_o = r_cfgerr;

endmodule

// File: doc/baud_generate.md
BAUD_GENERATE -- requirements
Module: baud_generate

Interface
REQ-001 Parameter MIN_PERIOD, default 2; smallest usable round-down period in clocks.
REQ-002 clk  in  1  system clock; all logic on rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-low.
REQ-004 p_Enable_i  in  1  level; 1 runs bit timing, 0 forces IDLE.
REQ-005 p_Restart_i  in  1  one-clock pulse; realign to a new bit, e.g. on an rx start-bit edge.
REQ-006 BaudRateGen_i  in  16  round-down acquisition period in clocks, from control-register block.
REQ-007 BitCompensateMethod_i  in  8  [7:4] round-up period count per bit, [3:0] round-down count per bit.
REQ-008 p_AcqSig_o  out  1  one-clock acquisition strobe.
REQ-009 p_BitEnd_o  out  1  one-clock pulse coincident with last strobe of a bit.
REQ-010 AcqIdx_o  out  5  1-based index of current strobe within bit; valid while p_AcqSig_o=1.
REQ-011 p_Busy_o  out  1  1 when state is not IDLE.
REQ-012 p_CfgErr_o  out  1  sticky; 1 when a bit start saw up count + down count = 0.

Function
REQ-013 States SHALL be IDLE, UP_PHASE and DOWN_PHASE.
REQ-014 Config SHALL latch only at bit start: leaving IDLE, at bit end, or on restart; mid-bit input changes SHALL be ignored until the next bit.
REQ-015 Effective period P SHALL be max(BaudRateGen_i, MIN_PERIOD); UP_PHASE intervals are P+1 clocks, DOWN_PHASE intervals are P clocks.
REQ-016 Strobes per bit N SHALL be up+down, computed 5 bits wide; no 4-bit overflow, since 15+15=30.
REQ-017 IDLE with p_Enable_i=1 at edge E0 SHALL enter UP_PHASE, or DOWN_PHASE if up=0, with period counter 0; first p_AcqSig_o SHALL be high in the cycle after edge E0+L, where L is that phase's interval.
REQ-018 Each strobe SHALL last exactly one clock, with no gap beyond the interval between consecutive strobes.
REQ-019 UP_PHASE SHALL move to DOWN_PHASE after the up-th strobe; with down=0 the bit SHALL end there.
REQ-020 At the N-th strobe, p_BitEnd_o=1 and AcqIdx_o=N; with p_Enable_i=1 the next bit SHALL start on the following clock with no idle cycle, otherwise go to IDLE.
REQ-021 With N=0 at bit start, the block SHALL stay in IDLE, set p_CfgErr_o, and emit no strobes; p_CfgErr_o SHALL clear only on reset.
REQ-022 p_Enable_i=0 in any state SHALL force IDLE at the next edge; a pending strobe or bit end SHALL be suppressed; the partial bit is discarded.
REQ-023 p_Restart_i=1 with p_Enable_i=1 SHALL clear counters, relatch config, and start a new bit; it takes priority over a strobe due in that same cycle, which SHALL be suppressed.
REQ-024 p_Restart_i with p_Enable_i=0 SHALL be ignored.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 During reset, state=IDLE, counters=0, and p_AcqSig_o, p_BitEnd_o, p_Busy_o, p_CfgErr_o=0, AcqIdx_o=0.
REQ-027 Reset asserted mid-bit SHALL abort immediately and asynchronously; after release, operation restarts per REQ-017 once p_Enable_i is sampled high.

Structure
REQ-028 A shared package baud_pkg SHALL hold the state enum, MIN_PERIOD default, and width constants (period 16, per-phase count 4, index 5).
REQ-029 One sub-module, baud_period_counter, SHALL hold the 16-bit interval counter with load/clear and terminal-count output; phase and strobe counting SHALL stay in baud_generate.

Verification
REQ-030 Config 20/up 10/down 5, enable held: 10 intervals of 21 clocks then 5 of 20; bit = 310 clocks; BitEnd at AcqIdx=15; next bit begins back-to-back.
REQ-031 BaudRateGen changed 20->30 at strobe 3: current bit keeps 20/21-clock intervals; the next bit uses 30/31.
REQ-032 Restart pulse at strobe-due cycle of strobe 7: no strobe 7; next strobe 21 clocks later with AcqIdx=1.
REQ-033 Enable dropped mid DOWN_PHASE: next cycle Busy=0 with no further strobes; re-enable gives first strobe after 21 clocks.
REQ-034 Up=0, down=0: CfgErr=1, Busy=0, no strobes; BaudRateGen=1, up=0, down=3: intervals of 2 clocks, BitEnd at AcqIdx=3.
REQ-035 Up=15, down=15: 30 strobes with AcqIdx reaching 30 and no wrap; async reset mid-bit clears all outputs without waiting for a clock.
